// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 data mux with a bounded burst per grant.
// o follows the registered select; hand-off between owners has no idle bubble.
module mux_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int SWIDTH    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [WIDTH-1:0]  i0,
    input  logic [WIDTH-1:0]  i1,
    input  logic [WIDTH-1:0]  i2,
    input  logic [WIDTH-1:0]  i3,
    input  logic              o_ready,
    output logic [WIDTH-1:0]  o,
    output logic              o_valid,
    output logic [SWIDTH-1:0] sel,
    output logic [3:0]        gnt
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [1:0]    owner;
    logic [1:0]    last;
    logic [CW-1:0] cnt;

    logic          xfer;
    logic          release_now;
    logic [2:0]    idle_pick;
    logic [2:0]    next_pick;

    // Returns {found, index}: first set bit searched from one past 'from',
    // so 'from' itself is considered last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int j = 4; j >= 1; j--) begin
            k = from + 2'(j);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign sel     = owner;
    assign o_valid = (state == GRANT) && req[owner];
    assign xfer    = o_valid && o_ready;

    // Under an early drop req[owner] is already 0, so the raw req serves as
    // the masked request vector in both release cases.
    assign release_now = (state == GRANT) &&
                         (!req[owner] || (xfer && (cnt == CNT_LAST)));
    assign idle_pick   = rr_pick(req, last);
    assign next_pick   = rr_pick(req, owner);

    always_comb begin
        o = i0;
        case (sel)
            2'd0:    o = i0;
            2'd1:    o = i1;
            2'd2:    o = i2;
            default: o = i3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            owner <= 2'd0;
            cnt   <= '0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        state <= GRANT;
                        owner <= idle_pick[1:0];
                        gnt   <= 4'b0001 << idle_pick[1:0];
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (release_now) begin
                        last <= owner;
                        if (next_pick[2]) begin
                            owner <= next_pick[1:0];
                            gnt   <= 4'b0001 << next_pick[1:0];
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a plain round-robin reference model.
module tb_mux_rr_arbiter;

    localparam int WIDTH = 4;
    localparam int MB    = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] d [4];
    logic             o_ready;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic [1:0]       sel;
    logic [3:0]       gnt;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_busy;
    int m_owner, m_last, m_cnt;

    mux_rr_arbiter #(.WIDTH(WIDTH), .SWIDTH(2), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(d[0]), .i1(d[1]), .i2(d[2]), .i3(d[3]),
        .o_ready(o_ready), .o(o), .o_valid(o_valid), .sel(sel), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int rr_winner(input logic [3:0] r, input int from);
        for (int j = 1; j <= 4; j++)
            if (r[(from + j) % 4]) return (from + j) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 3; m_cnt = 0;
    endtask

    task automatic model_edge();
        int  w;
        bit  x;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            w = rr_winner(req, m_last);
            if (w >= 0) begin m_busy = 1; m_owner = w; m_cnt = 0; end
        end else begin
            x = req[m_owner] && o_ready;
            if (!req[m_owner] || (x && m_cnt == MB - 1)) begin
                m_last = m_owner;
                w = rr_winner(req, m_owner);
                if (w >= 0) begin m_owner = w; m_cnt = 0; end
                else m_busy = 0;
            end else if (x) begin
                m_cnt++;
            end
        end
    endtask

    // Called at a falling edge: drive, compare against the model, take the
    // rising edge, advance the model, and return at the next falling edge.
    task automatic step(input logic rn, input logic [3:0] rq, input logic rdy);
        rst_n = rn; req = rq; o_ready = rdy;
        #1;
        check("gnt",     gnt,     m_busy ? (1 << m_owner) : 0);
        check("sel",     sel,     m_owner);
        check("o_valid", o_valid, (m_busy && rq[m_owner]) ? 1 : 0);
        check("o",       o,       d[m_owner]);
        if (m_busy) check("cnt", dut.cnt, m_cnt);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rr;
        int k;
        clk = 0; rst_n = 0; req = 4'b0000; o_ready = 0;
        for (int i = 0; i < 4; i++) d[i] = WIDTH'(i + 5);
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset with all requesting, then release
        step(0, 4'b1111, 1);
        step(0, 4'b1111, 1);
        check("rst_gnt", gnt, 0);
        check("rst_sel", sel, 0);
        step(1, 4'b1111, 1);
        check("rst_rel_gnt", gnt, 4'b0001);
        check("rst_rel_sel", sel, 0);

        // Sole requester streaming incrementing data on source 2
        step(0, 4'b0000, 1);
        step(1, 4'b0100, 1);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            d[2] = WIDTH'(k);
            #1;
            check("stream_o", o, k % 16);
            check("stream_valid", o_valid, 1);
            step(1, 4'b0100, 1);
            check("stream_gnt", gnt, 4'b0100);
            k++;
        end

        // Full rotation: four transfers per owner, 0,1,2,3,0
        step(0, 4'b0000, 1);
        step(1, 4'b1111, 1);
        for (int i = 0; i < 17; i++) begin
            check("rot_sel", sel, (i / MB) % 4);
            step(1, 4'b1111, 1);
        end

        // Backpressure on owner 1
        step(0, 4'b0000, 1);
        step(1, 4'b0010, 1);
        step(1, 4'b0010, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b0010, 0);
            check("bp_cnt", dut.cnt, 1);
            check("bp_valid", o_valid, 1);
            check("bp_o", o, d[1]);
        end
        step(1, 4'b0010, 1);
        step(1, 4'b0010, 1);
        check("bp_cnt3", dut.cnt, 3);
        step(1, 4'b0010, 1);
        check("bp_regrant_cnt", dut.cnt, 0);
        check("bp_regrant_gnt", gnt, 4'b0010);

        // Early drop by owner 1 with 3 and 0 waiting
        step(0, 4'b0000, 1);
        step(1, 4'b0010, 1);
        step(1, 4'b1011, 1);
        step(1, 4'b1011, 1);
        step(1, 4'b1001, 1);
        check("drop_gnt", gnt, 4'b1000);
        check("drop_sel", sel, 3);
        for (int i = 0; i < MB; i++) step(1, 4'b1001, 1);
        check("drop_next_gnt", gnt, 4'b0001);

        // Reset during owner 2's third transfer, then idle return
        step(0, 4'b0000, 1);
        step(1, 4'b0100, 1);
        step(1, 4'b0100, 1);
        step(1, 4'b0100, 1);
        step(0, 4'b0100, 1);
        check("midrst_gnt", gnt, 0);
        check("midrst_valid", o_valid, 0);
        step(1, 4'b0100, 1);
        check("midrst_regnt", gnt, 4'b0100);
        check("midrst_cnt", dut.cnt, 0);
        step(1, 4'b0000, 1);
        step(1, 4'b0000, 1);
        check("idle_gnt", gnt, 0);

        // Random traffic with sticky requests
        rr = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) rr[b] = ~rr[b];
            for (int s = 0; s < 4; s++) d[s] = WIDTH'($urandom);
            step(($urandom_range(99) != 0), rr, ($urandom_range(3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
